// File: rtl/if_prefetch_queue_if.sv
// Bundle of the memory fetch port and the IF-side queue port of the prefetch unit.
// "master" is the prefetcher's view; "slave" is the memory / IF stage side.
interface if_prefetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_npc;

    modport master (
        output mem_req, mem_addr, out_valid, out_ir, out_npc,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, deq
    );

    modport slave (
        input  mem_req, mem_addr, out_valid, out_ir, out_npc,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, deq
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetcher: one outstanding memory request, a small {instr, pc+4} FIFO,
// and a redirect that flushes the queue and turns any in-flight response stale.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    if_prefetch_queue_if.master     io_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t         r_state;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_req_pc;
    logic [CW-1:0]  r_count;
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [31:0]    r_ir  [DEPTH];
    logic [31:0]    r_npc [DEPTH];

    logic           w_req;
    logic           w_grant;
    logic           w_push;
    logic           w_pop;
    logic           w_out_valid;
    logic [31:0]    w_redirect_pc;
    logic [1:0]     w_unused_rpc_bits;

    assign w_redirect_pc     = {io_bus.redirect_pc[31:2], 2'b00};
    assign w_unused_rpc_bits = io_bus.redirect_pc[1:0];

    // Space is reserved at issue time: count can only drop while the request is in flight.
    assign w_req   = (r_state == S_FETCH) & rst & ~io_bus.redirect & (r_count < CW'(DEPTH));
    assign w_grant = w_req & io_bus.mem_gnt;
    assign w_push  = rst & (r_state == S_WAIT) & io_bus.mem_rvalid & ~io_bus.redirect;
    assign w_out_valid = rst & (r_count != '0);
    assign w_pop   = io_bus.deq & w_out_valid & ~io_bus.redirect;

    assign io_bus.mem_req   = w_req;
    assign io_bus.mem_addr  = r_fetch_pc;
    assign io_bus.out_valid = w_out_valid;
    assign io_bus.out_ir    = w_out_valid ? r_ir[r_head]  : 32'h0;
    assign io_bus.out_npc   = w_out_valid ? r_npc[r_head] : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            if (io_bus.redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_grant) begin
                    r_req_pc   <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) r_tail <= r_tail + AW'(1);
                if (w_pop)  r_head <= r_head + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end

            // A redirect while waiting leaves the response owed but no longer wanted.
            case (r_state)
                S_FETCH: if (w_grant) r_state <= S_WAIT;
                S_WAIT: begin
                    if (io_bus.mem_rvalid)    r_state <= S_FETCH;
                    else if (io_bus.redirect) r_state <= S_DROP;
                end
                S_DROP:  if (io_bus.mem_rvalid) r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ir[r_tail]  <= io_bus.mem_rdata;
            r_npc[r_tail] <= r_req_pc + 32'd4;
        end
    end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for the prefetch queue: a per-cycle vector table followed by
// hand-written fill / back-pressure / wrap sequences.
module tb_if_prefetch_queue;
    logic clk;
    logic rst;

    if_prefetch_queue_if bus ();

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        deq;
        logic        req;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] ir;
        logic [31:0] npc;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] I0 = 32'hA000_0000, I1 = 32'hA000_0001, I2 = 32'hA000_0002;
    localparam logic [31:0] I3 = 32'hA000_0003, I4 = 32'hA000_0004, I5 = 32'hA000_0005;
    localparam logic [31:0] I6 = 32'hA000_0006, I7 = 32'hA000_0007;
    localparam logic [31:0] W0 = 32'hB000_0000;

    function automatic vec_t mk(logic r, logic g, logic v, logic [31:0] d, logic rd,
                                logic [31:0] rp, logic dq, logic q, logic [31:0] a,
                                logic o, logic [31:0] i, logic [31:0] n);
        vec_t t;
        t.rst = r; t.gnt = g; t.rv = v; t.rdata = d; t.redir = rd; t.rpc = rp; t.deq = dq;
        t.req = q; t.addr = a; t.ov = o; t.ir = i; t.npc = n;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic g, input logic v, input logic [31:0] d,
                       input logic rd, input logic [31:0] rp, input logic dq);
        @(negedge clk);
        rst = r;
        bus.mem_gnt = g; bus.mem_rvalid = v; bus.mem_rdata = d;
        bus.redirect = rd; bus.redirect_pc = rp; bus.deq = dq;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic q, input logic [31:0] a,
                           input logic o, input logic [31:0] i, input logic [31:0] n);
        chk({tag, " req"},  {31'h0, bus.mem_req},   {31'h0, q});
        chk({tag, " addr"}, bus.mem_addr,           a);
        chk({tag, " ov"},   {31'h0, bus.out_valid}, {31'h0, o});
        chk({tag, " ir"},   bus.out_ir,             i);
        chk({tag, " npc"},  bus.out_npc,            n);
        $display("%s: req=%0b addr=%h ov=%0b ir=%h npc=%h", tag,
                 bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_ir, bus.out_npc);
    endtask

    initial begin
        //                rst gnt rv rdata        redir rpc           deq | req addr          ov ir  npc
        vecs[0]  = mk(0, 0, 0, 32'h0, 0, 32'h0,      0, 0, 32'h0,   0, 32'h0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 1, 32'h0,   0, 32'h0, 32'h0);
        vecs[2]  = mk(1, 1, 1, I0,    0, 32'h0,      0, 0, 32'h4,   0, 32'h0, 32'h0);
        vecs[3]  = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 1, 32'h4,   1, I0,    32'h4);
        vecs[4]  = mk(1, 0, 1, I1,    0, 32'h0,      0, 0, 32'h8,   1, I0,    32'h4);
        vecs[5]  = mk(1, 1, 0, 32'h0, 0, 32'h0,      1, 1, 32'h8,   1, I0,    32'h4);
        vecs[6]  = mk(1, 0, 1, I2,    0, 32'h0,      0, 0, 32'hC,   1, I1,    32'h8);
        vecs[7]  = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 1, 32'hC,   1, I1,    32'h8);
        // redirect coincident with rvalid while two entries are queued
        vecs[8]  = mk(1, 0, 1, I3,    1, 32'h203,    1, 0, 32'h10,  1, I1,    32'h8);
        vecs[9]  = mk(1, 0, 0, 32'h0, 0, 32'h0,      0, 1, 32'h200, 0, 32'h0, 32'h0);
        vecs[10] = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 1, 32'h200, 0, 32'h0, 32'h0);
        // redirect while waiting; response arrives three cycles later and is dropped
        vecs[11] = mk(1, 1, 0, 32'h0, 1, 32'h43,     0, 0, 32'h204, 0, 32'h0, 32'h0);
        vecs[12] = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 0, 32'h40,  0, 32'h0, 32'h0);
        vecs[13] = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 0, 32'h40,  0, 32'h0, 32'h0);
        vecs[14] = mk(1, 0, 1, I4,    0, 32'h0,      0, 0, 32'h40,  0, 32'h0, 32'h0);
        vecs[15] = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 1, 32'h40,  0, 32'h0, 32'h0);
        vecs[16] = mk(1, 0, 1, I5,    0, 32'h0,      0, 0, 32'h44,  0, 32'h0, 32'h0);
        vecs[17] = mk(1, 0, 0, 32'h0, 0, 32'h0,      1, 1, 32'h44,  1, I5,    32'h44);
        // deq on an empty queue is ignored
        vecs[18] = mk(1, 0, 0, 32'h0, 0, 32'h0,      1, 1, 32'h44,  0, 32'h0, 32'h0);
        // redirect in FETCH suppresses the request even with gnt high
        vecs[19] = mk(1, 1, 0, 32'h0, 1, 32'h100,    0, 0, 32'h44,  0, 32'h0, 32'h0);
        vecs[20] = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 1, 32'h100, 0, 32'h0, 32'h0);
        // reset during WAIT; the stale response shows up after release
        vecs[21] = mk(0, 0, 0, 32'h0, 0, 32'h0,      0, 0, 32'h104, 0, 32'h0, 32'h0);
        vecs[22] = mk(1, 0, 1, I6,    0, 32'h0,      0, 1, 32'h0,   0, 32'h0, 32'h0);
        vecs[23] = mk(1, 1, 0, 32'h0, 0, 32'h0,      0, 1, 32'h0,   0, 32'h0, 32'h0);
        vecs[24] = mk(1, 0, 1, I7,    0, 32'h0,      0, 0, 32'h4,   0, 32'h0, 32'h0);
        vecs[25] = mk(1, 0, 0, 32'h0, 0, 32'h0,      0, 1, 32'h4,   1, I7,    32'h4);
        // outputs forced low while reset is held, and the queue is cleared by it
        vecs[26] = mk(0, 0, 0, 32'h0, 0, 32'h0,      0, 0, 32'h4,   0, 32'h0, 32'h0);
        vecs[27] = mk(1, 0, 0, 32'h0, 0, 32'h0,      0, 1, 32'h0,   0, 32'h0, 32'h0);

        rst = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.deq = 1'b0;
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].rst, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                vecs[i].redir, vecs[i].rpc, vecs[i].deq);
            chk_out($sformatf("v%0d", i), vecs[i].req, vecs[i].addr,
                    vecs[i].ov, vecs[i].ir, vecs[i].npc);
        end

        // Fill to DEPTH with deq held low, then back-pressure and wrap.
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 32'h0, 0, 32'h0, 0);
            chk($sformatf("fill%0d req", i), {31'h0, bus.mem_req}, 32'h1);
            chk($sformatf("fill%0d addr", i), bus.mem_addr, 32'(4 * i));
            $display("fill%0d: addr=%h", i, bus.mem_addr);
            cyc(1, 0, 1, W0 + 32'(i), 0, 32'h0, 0);
        end
        cyc(1, 1, 0, 32'h0, 0, 32'h0, 0);
        chk_out("full", 1'b0, 32'h10, 1'b1, W0, 32'h4);
        cyc(1, 1, 0, 32'h0, 0, 32'h0, 1);
        chk_out("full_deq", 1'b0, 32'h10, 1'b1, W0, 32'h4);
        cyc(1, 1, 0, 32'h0, 0, 32'h0, 0);
        chk_out("reopen", 1'b1, 32'h10, 1'b1, W0 + 32'd1, 32'h8);
        // push and pop together at count DEPTH-1; the push lands in the wrapped slot 0
        cyc(1, 0, 1, W0 + 32'd4, 0, 32'h0, 1);
        chk_out("pushpop", 1'b0, 32'h14, 1'b1, W0 + 32'd1, 32'h8);
        cyc(1, 0, 0, 32'h0, 0, 32'h0, 1);
        chk_out("drain0", 1'b1, 32'h14, 1'b1, W0 + 32'd2, 32'hC);
        cyc(1, 0, 0, 32'h0, 0, 32'h0, 1);
        chk_out("drain1", 1'b1, 32'h14, 1'b1, W0 + 32'd3, 32'h10);
        cyc(1, 0, 0, 32'h0, 0, 32'h0, 1);
        chk_out("drain2", 1'b1, 32'h14, 1'b1, W0 + 32'd4, 32'h14);
        cyc(1, 0, 0, 32'h0, 0, 32'h0, 0);
        chk_out("empty", 1'b1, 32'h14, 1'b0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
